// File: rtl/cmdin_reader_pkg.sv
// rtl/cmdin_reader_pkg.sv - shared command header layout, codes and length decode
package cmdin_reader_pkg;

    localparam int QUEUE_SLOTS = 64;
    localparam int SLOT_BITS   = 6;
    localparam int LEN_BITS    = 7;

    // Header field offsets (LSB of each byte field)
    localparam int HDR_CMD_TYPE_LSB = 0;
    localparam int HDR_NUM_ARGS_LSB = 8;
    localparam int HDR_COMPF_LSB    = 16;
    localparam int HDR_DESTID_LSB   = 32;
    localparam int HDR_VALID_LSB    = 56;

    localparam logic [7:0] ENTRY_VALID = 8'h80;
    localparam logic [7:0] ENTRY_FREE  = 8'h00;

    localparam logic [7:0] EXEC_TASK_CODE      = 8'd0;
    localparam logic [7:0] SETUP_HW_INST_CODE  = 8'd1;
    localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'd5;

    function automatic logic is_known_code(input logic [7:0] code);
        return (code == EXEC_TASK_CODE) || (code == SETUP_HW_INST_CODE) ||
               (code == EXEC_PERI_TASK_CODE);
    endfunction

    // Command length in slots, header included; 0 for an unknown code
    function automatic logic [LEN_BITS-1:0] get_cmd_length(input logic [7:0] code,
                                                           input logic [7:0] num_args);
        logic [LEN_BITS-1:0] two_n;
        two_n = LEN_BITS'({num_args, 1'b0});
        case (code)
            EXEC_TASK_CODE:      get_cmd_length = 7'd3 + two_n;
            SETUP_HW_INST_CODE:  get_cmd_length = 7'd2;
            EXEC_PERI_TASK_CODE: get_cmd_length = 7'd4 + two_n;
            default:             get_cmd_length = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmdin_reader_if.sv
// rtl/cmdin_reader_if.sv - cmdin memory port B plus accelerator command stream
interface cmdin_reader_if #(
    parameter int ACC_BITS = 4
);
    logic                cmdin_en;
    logic [7:0]          cmdin_wr;
    logic [31:0]         cmdin_addr;
    logic [63:0]         cmdin_din;
    logic [63:0]         cmdin_dout;

    logic [63:0]         out_tdata;
    logic                out_tvalid;
    logic                out_tready;
    logic                out_tlast;
    logic [ACC_BITS-1:0] out_tdest;

    modport master (
        output cmdin_en, cmdin_wr, cmdin_addr, cmdin_din,
        input  cmdin_dout,
        output out_tdata, out_tvalid, out_tlast, out_tdest,
        input  out_tready
    );

    modport slave (
        input  cmdin_en, cmdin_wr, cmdin_addr, cmdin_din,
        output cmdin_dout,
        input  out_tdata, out_tvalid, out_tlast, out_tdest,
        output out_tready
    );
endinterface

// File: rtl/cmdin_reader.sv
// rtl/cmdin_reader.sv - round-robin cmdin queue reader streaming commands to accelerators
module cmdin_reader
    import cmdin_reader_pkg::*;
#(
    parameter int NUM_ACCS = 16,
    localparam int ACC_BITS = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    cmdin_reader_if.master bus,
    output logic           bad_cmd
);

    typedef enum logic [2:0] {
        READ_HDR,
        CHECK_HDR,
        SEND,
        READ_WORD,
        LOAD,
        CLEAR
    } state_t;

    state_t                state, state_nxt;
    logic [ACC_BITS-1:0]   cur_acc;
    logic [ACC_BITS-1:0]   next_acc;
    logic [SLOT_BITS-1:0]  rd_idx [NUM_ACCS];
    logic [SLOT_BITS-1:0]  head_slot;
    logic [LEN_BITS-1:0]   cnt;
    logic [LEN_BITS-1:0]   len;

    logic [63:0]           tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [ACC_BITS-1:0]   tdest_q;

    logic                  hdr_valid;
    logic                  hdr_known;
    logic [LEN_BITS-1:0]   hdr_len;

    logic                  mem_en;
    logic [7:0]            mem_wr;
    logic [SLOT_BITS-1:0]  mem_slot;
    logic [63:0]           mem_din;

    assign head_slot = rd_idx[cur_acc];
    assign next_acc  = (cur_acc == ACC_BITS'(NUM_ACCS - 1)) ? '0 : cur_acc + 1'b1;
    assign hdr_valid = bus.cmdin_dout[HDR_VALID_LSB +: 8] == ENTRY_VALID;
    assign hdr_known = is_known_code(bus.cmdin_dout[HDR_CMD_TYPE_LSB +: 8]);
    assign hdr_len   = get_cmd_length(bus.cmdin_dout[HDR_CMD_TYPE_LSB +: 8],
                                      bus.cmdin_dout[HDR_NUM_ARGS_LSB +: 8]);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= READ_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            READ_HDR:  state_nxt = CHECK_HDR;
            CHECK_HDR: begin
                if (!hdr_valid) begin
                    state_nxt = READ_HDR;
                end else if (!hdr_known) begin
                    state_nxt = CLEAR;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.out_tready) begin
                    state_nxt = tlast_q ? CLEAR : READ_WORD;
                end
            end
            READ_WORD: state_nxt = LOAD;
            LOAD:      state_nxt = SEND;
            CLEAR:     state_nxt = READ_HDR;
            default:   state_nxt = READ_HDR;
        endcase
    end

    // Memory port: one access per cycle; the only write clears the header valid byte
    always_comb begin
        mem_en   = 1'b0;
        mem_wr   = 8'h00;
        mem_slot = head_slot;
        mem_din  = 64'd0;
        case (state)
            READ_HDR:  mem_en = 1'b1;
            READ_WORD: begin
                mem_en   = 1'b1;
                mem_slot = head_slot + cnt[SLOT_BITS-1:0];
            end
            CLEAR: begin
                mem_en  = 1'b1;
                mem_wr  = 8'h80;
                mem_din = {ENTRY_FREE, 56'd0};
            end
            default: ;
        endcase
        if (!rstn) begin
            mem_en = 1'b0;
            mem_wr = 8'h00;
        end
    end

    assign bus.cmdin_en   = mem_en;
    assign bus.cmdin_wr   = mem_wr;
    assign bus.cmdin_addr = {23'(cur_acc), mem_slot, 3'b000};
    assign bus.cmdin_din  = mem_din;

    assign bus.out_tdata  = tdata_q;
    assign bus.out_tvalid = tvalid_q;
    assign bus.out_tlast  = tlast_q;
    assign bus.out_tdest  = tdest_q;

    // Datapath: queue pointers, beat counter, stream registers, sticky error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_acc  <= '0;
            for (int i = 0; i < NUM_ACCS; i++) begin
                rd_idx[i] <= '0;
            end
            cnt      <= '0;
            len      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdest_q  <= '0;
            bad_cmd  <= 1'b0;
        end else begin
            case (state)
                CHECK_HDR: begin
                    if (!hdr_valid) begin
                        cur_acc <= next_acc;
                    end else if (!hdr_known) begin
                        bad_cmd <= 1'b1;
                        len     <= 7'd1;
                    end else begin
                        tdata_q  <= bus.cmdin_dout;
                        len      <= hdr_len;
                        cnt      <= 7'd1;
                        tvalid_q <= 1'b1;
                        tdest_q  <= cur_acc;
                        tlast_q  <= (hdr_len == 7'd1);
                    end
                end
                SEND: begin
                    if (bus.out_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    tdata_q  <= bus.cmdin_dout;
                    tvalid_q <= 1'b1;
                    tlast_q  <= (cnt == len - 7'd1);
                    cnt      <= cnt + 7'd1;
                end
                CLEAR: begin
                    rd_idx[cur_acc] <= head_slot + len[SLOT_BITS-1:0];
                    cur_acc         <= next_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmdin_reader.sv
// tb/tb_cmdin_reader.sv - scoreboard bench for cmdin_reader with a cmdin memory model
module tb_cmdin_reader;
    import cmdin_reader_pkg::*;

    localparam int NUM_ACCS = 16;
    localparam int ACC_BITS = 4;

    localparam logic [63:0] HDR_EXEC_N2  = 64'h8000_0000_0000_0200;
    localparam logic [63:0] HDR_EXEC_N1  = 64'h8000_0000_0000_0100;
    localparam logic [63:0] HDR_SETUP    = 64'h8000_0000_0000_0001;
    localparam logic [63:0] HDR_BAD9     = 64'h8000_0000_0000_0009;

    typedef struct packed {
        logic [63:0]         data;
        logic                last;
        logic [ACC_BITS-1:0] dest;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  wr;
        logic [7:0]  top;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    logic bad_cmd;

    cmdin_reader_if #(.ACC_BITS(ACC_BITS)) bus();

    cmdin_reader #(.NUM_ACCS(NUM_ACCS)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .bad_cmd (bad_cmd)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [NUM_ACCS][QUEUE_SLOTS];
    logic        host_we;
    logic        host_clr;
    int          host_acc;
    int          host_slot;
    logic [63:0] host_data;

    beat_t exp_beats[$];
    wr_t   exp_wr[$];
    int    n_vec;
    int    n_miss;
    int    beat_cnt;
    int    wr_cnt;

    logic        prev_stall;
    beat_t       prev_beat;

    // cmdin BRAM port B model plus a host-side write port
    always @(posedge clk) begin
        if (host_clr) begin
            for (int a = 0; a < NUM_ACCS; a++)
                for (int s = 0; s < QUEUE_SLOTS; s++)
                    mem[a][s] <= 64'd0;
        end else if (host_we) begin
            mem[host_acc][host_slot] <= host_data;
        end
        if (bus.cmdin_en) begin
            if (bus.cmdin_wr == 8'h00) begin
                bus.cmdin_dout <= mem[bus.cmdin_addr[12:9]][bus.cmdin_addr[8:3]];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (bus.cmdin_wr[b])
                        mem[bus.cmdin_addr[12:9]][bus.cmdin_addr[8:3]][8*b +: 8] <= bus.cmdin_din[8*b +: 8];
            end
        end
    end

    function automatic logic [63:0] word_val(input int acc, input int slot, input int i);
        return {8'h11, 8'(acc), 8'(slot), 8'(i), 32'h5A5A_0000};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input int acc, input int slot, input logic [63:0] data);
        host_acc  = acc;
        host_slot = slot;
        host_data = data;
        host_we   = 1'b1;
        @(posedge clk);
        #1 host_we = 1'b0;
    endtask

    task automatic exp_push(input int acc, input int slot, input logic [63:0] hdr,
                            input int len, input bit with_clear);
        beat_t b;
        wr_t   w;
        b.data = hdr;
        b.last = (len == 1);
        b.dest = ACC_BITS'(acc);
        exp_beats.push_back(b);
        for (int i = 1; i < len; i++) begin
            b.data = word_val(acc, (slot + i) % QUEUE_SLOTS, i);
            b.last = (i == len - 1);
            exp_beats.push_back(b);
        end
        if (with_clear) begin
            w.addr = (acc << 9) | (slot << 3);
            w.wr   = 8'h80;
            w.top  = 8'h00;
            exp_wr.push_back(w);
        end
    endtask

    task automatic mem_load(input int acc, input int slot, input logic [63:0] hdr, input int len);
        for (int i = 1; i < len; i++)
            host_write(acc, (slot + i) % QUEUE_SLOTS, word_val(acc, (slot + i) % QUEUE_SLOTS, i));
        host_write(acc, slot, hdr);
    endtask

    task automatic put_cmd(input int acc, input int slot, input logic [63:0] hdr, input int len);
        exp_push(acc, slot, hdr, len, 1'b1);
        mem_load(acc, slot, hdr, len);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_beats.size() != 0 || exp_wr.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_vec++;
        if (exp_beats.size() != 0 || exp_wr.size() != 0) begin
            n_miss++;
            $display("FAIL %s_timeout: %0d beats and %0d writes pending, required 0",
                     name, exp_beats.size(), exp_wr.size());
            exp_beats.delete();
            exp_wr.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (beat_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_reached"}, 64'(beat_cnt >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        n_vec      = 0;
        n_miss     = 0;
        beat_cnt   = 0;
        wr_cnt     = 0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        rstn       = 1'b0;
        host_we    = 1'b0;
        host_clr   = 1'b1;
        host_acc   = 0;
        host_slot  = 0;
        host_data  = 64'd0;
        bus.out_tready = 1'b1;

        // Monitor: pops the scoreboard on every handshake and every memory write
        fork
            forever begin
                beat_t ab;
                beat_t eb;
                wr_t   aw;
                wr_t   ew;
                @(negedge clk);
                if (rstn) begin
                    ab = {bus.out_tdata, bus.out_tlast, bus.out_tdest};
                    if (prev_stall) begin
                        n_vec++;
                        if (!(bus.out_tvalid === 1'b1 && ab === prev_beat && bus.cmdin_en === 1'b0)) begin
                            n_miss++;
                            $display("FAIL stall_hold: got valid %b beat %h en %b, required valid 1 beat %h en 0",
                                     bus.out_tvalid, ab, bus.cmdin_en, prev_beat);
                        end
                    end
                    if (bus.out_tvalid && bus.out_tready) begin
                        n_vec++;
                        beat_cnt++;
                        if (exp_beats.size() == 0) begin
                            n_miss++;
                            $display("FAIL beat_unexpected: got %h, required no beat", ab);
                        end else begin
                            eb = exp_beats.pop_front();
                            if (ab !== eb) begin
                                n_miss++;
                                $display("FAIL beat: got data %h last %b dest %0d, required data %h last %b dest %0d",
                                         ab.data, ab.last, ab.dest, eb.data, eb.last, eb.dest);
                            end
                        end
                    end
                    if (bus.cmdin_en && bus.cmdin_wr != 8'h00) begin
                        n_vec++;
                        wr_cnt++;
                        aw = {bus.cmdin_addr, bus.cmdin_wr, bus.cmdin_din[63:56]};
                        if (exp_wr.size() == 0) begin
                            n_miss++;
                            $display("FAIL write_unexpected: got addr %h wr %h, required no write",
                                     aw.addr, aw.wr);
                        end else begin
                            ew = exp_wr.pop_front();
                            if (aw !== ew) begin
                                n_miss++;
                                $display("FAIL clear_write: got addr %h wr %h top %h, required addr %h wr %h top %h",
                                         aw.addr, aw.wr, aw.top, ew.addr, ew.wr, ew.top);
                            end
                        end
                    end
                    prev_stall = bus.out_tvalid && !bus.out_tready;
                    prev_beat  = ab;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1 host_clr = 1'b0;
        @(negedge clk);
        check("rst_tvalid",  64'(bus.out_tvalid), 64'd0);
        check("rst_tlast",   64'(bus.out_tlast),  64'd0);
        check("rst_en",      64'(bus.cmdin_en),   64'd0);
        check("rst_wr",      64'(bus.cmdin_wr),   64'd0);
        check("rst_bad_cmd", 64'(bad_cmd),        64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Acc 3 slot 0: EXEC_TASK nArgs=2, seven beats then clear at 0x600
        put_cmd(3, 0, HDR_EXEC_N2, 7);
        wait_drain("t1", 500);
        check("t1_rd_idx3", 64'(dut.rd_idx[3]), 64'd7);
        check("t1_hdr_kept", mem[3][0], 64'h0000_0000_0000_0200);

        // Same command at slot 7 with beat 3 held off for 5 cycles
        base = beat_cnt;
        put_cmd(3, 7, HDR_EXEC_N2, 7);
        wait_beats("t2_beat2", base + 2, 500);
        #1 bus.out_tready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_tvalid && k < 50);
        check("t2_beat3_valid", 64'(bus.out_tvalid), 64'd1);
        repeat (5) @(posedge clk);
        #1 bus.out_tready = 1'b1;
        wait_drain("t2", 500);
        check("t2_rd_idx3", 64'(dut.rd_idx[3]), 64'd14);
        check("t2_beats", 64'(beat_cnt - base), 64'd7);

        // Park the scanner on acc 15, then queue two SETUP commands on acc 0 and acc 1
        bus.out_tready = 1'b0;
        put_cmd(15, 0, HDR_SETUP, 2);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_tvalid && k < 200);
        check("t4_park_dest", 64'(bus.out_tdest), 64'd15);
        @(posedge clk);
        #1;
        put_cmd(0, 0, HDR_SETUP, 2);
        put_cmd(1, 0, HDR_SETUP, 2);
        put_cmd(0, 2, HDR_SETUP, 2);
        put_cmd(1, 2, HDR_SETUP, 2);
        bus.out_tready = 1'b1;
        wait_drain("t4", 1000);
        check("t4_rd_idx0", 64'(dut.rd_idx[0]), 64'd4);
        check("t4_rd_idx1", 64'(dut.rd_idx[1]), 64'd4);

        // Advance acc 0 to slot 62, then a wrapping EXEC_TASK nArgs=1
        for (int c = 0; c < 29; c++)
            put_cmd(0, 4 + 2 * c, HDR_SETUP, 2);
        wait_drain("fill", 6000);
        check("fill_rd_idx0", 64'(dut.rd_idx[0]), 64'd62);
        put_cmd(0, 62, HDR_EXEC_N1, 5);
        wait_drain("t3", 500);
        check("t3_rd_idx0", 64'(dut.rd_idx[0]), 64'd3);

        // Unknown code 9 at acc 2: no beats, sticky bad_cmd, valid byte cleared
        begin
            wr_t w;
            w.addr = 32'h0000_0400;
            w.wr   = 8'h80;
            w.top  = 8'h00;
            exp_wr.push_back(w);
        end
        host_write(2, 0, HDR_BAD9);
        wait_drain("t5", 500);
        check("t5_bad_cmd", 64'(bad_cmd), 64'd1);
        check("t5_rd_idx2", 64'(dut.rd_idx[2]), 64'd1);
        check("t5_hdr_cleared", mem[2][0], 64'h0000_0000_0000_0009);
        base = beat_cnt;
        k    = wr_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("t5_bad_sticky", 64'(bad_cmd), 64'd1);
        check("t5_idle_beats", 64'(beat_cnt), 64'(base));
        check("t5_idle_writes", 64'(wr_cnt), 64'(k));

        // Reset after beat 2 of a 5-beat command at acc 5, then a full re-stream
        base = beat_cnt;
        k    = wr_cnt;
        exp_push(5, 0, HDR_EXEC_N1, 5, 1'b0);
        mem_load(5, 0, HDR_EXEC_N1, 5);
        wait_beats("t6_beat2", base + 2, 500);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_beats.delete();
        exp_wr.delete();
        exp_push(5, 0, HDR_EXEC_N1, 5, 1'b1);
        @(negedge clk);
        check("t6_tvalid_low", 64'(bus.out_tvalid), 64'd0);
        check("t6_rd_idx5_rst", 64'(dut.rd_idx[5]), 64'd0);
        check("t6_bad_cmd_rst", 64'(bad_cmd), 64'd0);
        check("t6_no_clear", 64'(wr_cnt), 64'(k));
        base = beat_cnt;
        @(posedge clk);
        #1;
        wait_drain("t6", 500);
        check("t6_restream_beats", 64'(beat_cnt - base), 64'd5);
        check("t6_rd_idx5", 64'(dut.rd_idx[5]), 64'd5);
        check("t6_hdr_cleared", mem[5][0], 64'h0000_0000_0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
